// File: rtl/sram_pkg.sv
// Shared types and sizes for the asynchronous SRAM controller.
// The debug struct exposes FSM state, DAT drive enable and the ACCESS counter.
package sram_pkg;
  localparam int ADDR_W          = 19;
  localparam int DATA_W          = 16;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    state_t     state;
    logic       dat_oe;
    logic [3:0] cnt;
  } dbg_t;
endpackage

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle for sram_ctrl.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; rsp_valid is a one-cycle pulse with no back-pressure.
interface sram_ctrl_if;
  import sram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_dat_io.sv
// Bidirectional buffer for the SRAM data pins.
module sram_dat_io #(
  parameter int W = 16
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);
  assign pad = oe ? dout : {W{1'bz}};
  assign din = pad;
endmodule

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD.
// Every pin-facing output is a flop whose next value is derived from the next state.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  sram_ctrl_if.slave        host,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [DATA_W-1:0] DAT,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              RAMCS,
  output dbg_t              dbg
);
  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dat_oe_q, dat_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  logic              busy;
  logic [DATA_W-1:0] dat_in;

  sram_dat_io #(.W(DATA_W)) u_dat_io (
    .oe   (dat_oe_q),
    .dout (wdata_q),
    .din  (dat_in),
    .pad  (DAT)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (host.req_valid && ready_q) begin
          state_d = SETUP;
          addr_d  = host.req_addr;
          we_d    = host.req_we;
          wdata_d = host.req_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_RELOAD;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          // Data is captured while RAMOE is still low, on the edge ending ACCESS.
          if (!we_q) rdata_d = dat_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy        = (state_d != IDLE);
    ready_d     = !busy;
    cs_n_d      = !busy;
    oe_n_d      = !(!we_d && (state_d == SETUP || state_d == ACCESS));
    we_n_d      = !(we_d && state_d == ACCESS);
    dat_oe_d    = we_d && busy;
    rsp_valid_d = !we_d && (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dat_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dat_oe_q    <= dat_oe_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign ADR            = addr_q;
  assign RAMCS          = cs_n_q;
  assign RAMOE          = oe_n_q;
  assign RAMWE          = we_n_q;
  assign host.req_ready = ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rdata_q;
  assign dbg.state      = state_q;
  assign dbg.dat_oe     = dat_oe_q;
  assign dbg.cnt        = cnt_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 2, 1, 15) each with a small SRAM model,
// a request driver, and a per-instance monitor that pops an expected-access queue.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [N-1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [N-1:0] oe_n, we_n, cs_n, dat_oe;
  logic [18:0]  req_addr  [N];
  logic [15:0]  req_wdata [N];
  logic [15:0]  rsp_rdata [N];
  logic [18:0]  adr       [N];
  state_t       st        [N];

  // {dut index[1:0], we, addr[18:0], data[15:0]}
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int WCG = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    sram_ctrl_if host ();
    wire  [15:0] dat;
    logic [18:0] adr_w;
    logic        oe_n_w, we_n_w, cs_n_w;
    dbg_t        dbg_w;
    logic [15:0] mem [64];

    assign host.req_valid = req_valid[g];
    assign host.req_we    = req_we[g];
    assign host.req_addr  = req_addr[g];
    assign host.req_wdata = req_wdata[g];
    assign req_ready[g]   = host.req_ready;
    assign rsp_valid[g]   = host.rsp_valid;
    assign rsp_rdata[g]   = host.rsp_rdata;
    assign adr[g]         = adr_w;
    assign oe_n[g]        = oe_n_w;
    assign we_n[g]        = we_n_w;
    assign cs_n[g]        = cs_n_w;
    assign dat_oe[g]      = dbg_w.dat_oe;
    assign st[g]          = dbg_w.state;

    // SRAM model drives the bus whenever it is selected for a read.
    assign dat = (!cs_n_w && !oe_n_w) ? mem[adr_w[5:0]] : 16'hzzzz;

    sram_ctrl #(.WAIT_CYCLES(WCG)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .host   (host.slave),
      .ADR    (adr_w),
      .DAT    (dat),
      .RAMOE  (oe_n_w),
      .RAMWE  (we_n_w),
      .RAMCS  (cs_n_w),
      .dbg    (dbg_w)
    );

    initial for (int i = 0; i < 64; i++) mem[i] = 16'hD000 + 16'(i);

    int   cs_cnt = 0, oe_cnt = 0, we_cnt = 0, acc_cnt = 0, rsp_cnt = 0;
    logic prev_cs_n = 1'b1, prev_we_n = 1'b1;

    always @(negedge clk) begin : mon
      logic [37:0] f;
      logic        mine;
      mine = (exp_q.size() > 0) && (exp_q[0][37:36] == 2'(g));
      f    = mine ? exp_q[0] : '0;

      check($sformatf("d%0d_oe_we_both_low", g), 64'(!oe_n_w && !we_n_w), 0);
      check($sformatf("d%0d_dat_driven_oe_low", g), 64'(dbg_w.dat_oe && !oe_n_w), 0);
      check($sformatf("d%0d_rsp_spurious", g),
            64'(host.rsp_valid && !(resetn && !cs_n_w && mine && !f[35])), 0);

      if (!resetn) begin
        cs_cnt = 0; oe_cnt = 0; we_cnt = 0; acc_cnt = 0; rsp_cnt = 0;
      end else if (!cs_n_w) begin
        cs_cnt++;
        if (!oe_n_w) oe_cnt++;
        if (!we_n_w) we_cnt++;
        if (dbg_w.state == ACCESS) acc_cnt++;
        if (host.rsp_valid) rsp_cnt++;
        if (mine) begin
          check($sformatf("d%0d_adr", g), adr_w, f[34:16]);
          check($sformatf("d%0d_dat_drive", g), dbg_w.dat_oe, f[35]);
          if (f[35]) check($sformatf("d%0d_dat_wdata", g), dat, f[15:0]);
          if (host.rsp_valid) begin
            check($sformatf("d%0d_rsp_rdata", g), host.rsp_rdata, f[15:0]);
            check($sformatf("d%0d_rsp_latency", g), cs_cnt, WCG + 2);
          end
        end
      end else if (!prev_cs_n) begin
        if (mine) begin
          check($sformatf("d%0d_cs_low_cycles", g), cs_cnt, WCG + 2);
          check($sformatf("d%0d_access_cycles", g), acc_cnt, WCG);
          check($sformatf("d%0d_we_low_cycles", g), we_cnt, f[35] ? WCG : 0);
          check($sformatf("d%0d_oe_low_cycles", g), oe_cnt, f[35] ? 0 : WCG + 1);
          check($sformatf("d%0d_rsp_pulses", g), rsp_cnt, f[35] ? 0 : 1);
          void'(exp_q.pop_front());
        end
        cs_cnt = 0; oe_cnt = 0; we_cnt = 0; acc_cnt = 0; rsp_cnt = 0;
      end

      // Model write commit: RAMWE rising while the controller still drives DAT in HOLD.
      if (resetn && !prev_we_n && we_n_w) mem[adr_w[5:0]] = dat;
      prev_we_n = we_n_w;
      prev_cs_n = cs_n_w;
    end
  end

  task automatic issue(input int k, input logic we, input logic [18:0] a, input logic [15:0] d,
                       input bit push, input bit keep_valid, output int acc_cyc);
    int b;
    req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
    if (push) exp_q.push_back({2'(k), we, a, d});
    b = 0;
    while (!req_ready[k] && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready[k]) begin
      check("accept_timeout", 1, 0);
      req_valid[k] = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid[k] = 1'b0;
    req_we[k] = ~we; req_addr[k] = ~a; req_wdata[k] = ~d;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("queue_drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, t2, tr;
    resetn = 1'b0;
    req_valid = '0; req_we = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("d%0d_rst_adr", k), adr[k], 0);
      check($sformatf("d%0d_rst_strobes", k), {cs_n[k], oe_n[k], we_n[k]}, 3'b111);
      check($sformatf("d%0d_rst_dat_oe", k), dat_oe[k], 0);
      check($sformatf("d%0d_rst_rsp", k), {rsp_valid[k], rsp_rdata[k]}, 0);
      check($sformatf("d%0d_rst_ready", k), req_ready[k], 0);
      check($sformatf("d%0d_rst_state", k), st[k], IDLE);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1 check("ready_before_edge", req_ready, 3'b000);
    @(posedge clk);
    #1 check("ready_after_edge", req_ready, 3'b111);
    @(negedge clk);

    // Write then read back on every instance.
    for (int k = 0; k < N; k++) begin
      issue(k, 1'b1, 19'h1A2B5, 16'hBEEF, 1, 0, tr);
      issue(k, 1'b0, 19'h1A2B5, 16'hBEEF, 1, 0, tr);
      wait_drain();
    end
    check("adr_idle_hold", adr[0], 19'h1A2B5);
    check("rdata_held", rsp_rdata[0], 16'hBEEF);

    issue(0, 1'b1, 19'h00003, 16'h1234, 1, 0, tr);
    issue(0, 1'b0, 19'h00003, 16'h1234, 1, 0, tr);
    issue(0, 1'b0, 19'h1A2B5, 16'hBEEF, 1, 0, tr);
    wait_drain();

    // Back-to-back writes with req_valid held high.
    issue(0, 1'b1, 19'h7FFFF, 16'hFFFF, 1, 1, t0);
    issue(0, 1'b1, 19'h00000, 16'h0000, 1, 1, t1);
    issue(0, 1'b1, 19'h55555, 16'hA5A5, 1, 0, t2);
    check("b2b_gap_1", t1 - t0, 5);
    check("b2b_gap_2", t2 - t1, 5);
    issue(0, 1'b0, 19'h7FFFF, 16'hFFFF, 1, 0, tr);
    wait_drain();

    // Reset pulse during ACCESS of a write.
    issue(0, 1'b1, 19'h0ABCD, 16'h5A5A, 0, 0, tr);
    @(negedge clk);
    check("abort_in_access", st[0], ACCESS);
    #2 resetn = 1'b0;
    #1;
    check("abort_strobes", {cs_n[0], oe_n[0], we_n[0]}, 3'b111);
    check("abort_dat_released", dat_oe[0], 0);
    check("abort_rsp_valid", rsp_valid[0], 0);
    check("abort_adr", adr[0], 0);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("abort_ready_low", req_ready[0], 0);
    @(posedge clk);
    #1 check("abort_ready_release", req_ready[0], 1);
    @(negedge clk);

    issue(0, 1'b0, 19'h55555, 16'hA5A5, 1, 0, tr);
    wait_drain();
    check("post_abort_mem", gen_dut[0].mem[13], 16'hD00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
